// File: rtl/input_overlay_sequencer_if.sv
// ----------------------------------------------------------------------------
// input_overlay_sequencer_if
// Bundles the pixel-pipeline signals of the input-viewer overlay sequencer.
//   master : VGA timing / ROM side (drives x, y, video_on, frame_start,
//            buttons, base_data, fill_data; receives row, col, rgb,
//            rgb_valid, active_buttons)
//   slave  : the sequencer itself
// Signals:
//   x, y            screen coordinates from VGA timing
//   video_on        active-video flag aligned with x/y
//   frame_start     one-cycle pulse at start of vertical blank
//   buttons         raw asynchronous button levels, 1 = pressed
//   row, col        image-local address shared by all sprite ROMs
//   base_data       base image ROM output, 1 cycle after row/col
//   fill_data       fill ROM outputs, fill i at [12i+11:12i]
//   rgb, rgb_valid  composited pixel and its valid flag
//   active_buttons  frame-latched button state
// ----------------------------------------------------------------------------
interface input_overlay_sequencer_if #(
    parameter int N_FILL = 8
) ();
    logic [9:0]          x;
    logic [9:0]          y;
    logic                video_on;
    logic                frame_start;
    logic [N_FILL-1:0]   buttons;
    logic [7:0]          row;
    logic [9:0]          col;
    logic [11:0]         base_data;
    logic [12*N_FILL-1:0] fill_data;
    logic [11:0]         rgb;
    logic                rgb_valid;
    logic [N_FILL-1:0]   active_buttons;

    modport master (
        output x, y, video_on, frame_start, buttons, base_data, fill_data,
        input  row, col, rgb, rgb_valid, active_buttons
    );

    modport slave (
        input  x, y, video_on, frame_start, buttons, base_data, fill_data,
        output row, col, rgb, rgb_valid, active_buttons
    );
endinterface

// File: rtl/input_overlay_sequencer.sv
// ----------------------------------------------------------------------------
// input_overlay_sequencer
// Maps VGA screen coordinates into image-local row/col for the input-viewer
// sprite ROMs, frame-latches (optionally debounced) button state, and
// composites the base image with per-button fill overlays into one pixel.
// Ports:
//   clk    pixel clock
//   reset  synchronous, active-high reset
//   bus    input_overlay_sequencer_if.slave (see interface header)
// Pipeline: x/y at t -> row/col at t+1 -> ROM data at t+2 -> rgb at t+3.
// Build option: define INPUT_OVERLAY_DEBOUNCE_EN to insert a per-bit
// debouncer between the synchronizer and the frame latch; without it the
// synchronizer output feeds the frame latch directly.
// ----------------------------------------------------------------------------
module input_overlay_sequencer #(
    parameter int          ORIGIN_X        = 28,
    parameter int          ORIGIN_Y        = 156,
    parameter int          IMG_W           = 584,
    parameter int          IMG_H           = 167,
    parameter int          N_FILL          = 8,
    parameter int          DEBOUNCE_CYCLES = 250000,
    parameter logic [11:0] BG_COLOR        = 12'h000
) (
    input  logic                       clk,
    input  logic                       reset,
    input_overlay_sequencer_if.slave   bus
);
    // A debounce length below one cycle has no meaning.
    if (DEBOUNCE_CYCLES < 1) begin : g_cfg_check
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    localparam logic [10:0] X_LO = 11'(ORIGIN_X);
    localparam logic [10:0] X_HI = 11'(ORIGIN_X + IMG_W);
    localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
    localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + IMG_H);

    // ---------------- button path ----------------
    logic [N_FILL-1:0] sync1_q;
    logic [N_FILL-1:0] sync2_q;
    logic [N_FILL-1:0] dbnc_s;
    logic [N_FILL-1:0] active_q;

    // Two-flop synchronizer for the raw asynchronous button levels.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.buttons;
            sync2_q <= sync1_q;
        end
    end

`ifdef INPUT_OVERLAY_DEBOUNCE_EN
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } dbnc_state_e;

    dbnc_state_e       dbnc_state_q [N_FILL];
    logic [CNT_W-1:0]  dbnc_cnt_q   [N_FILL];
    logic [N_FILL-1:0] accepted_q;

    // Per-bit debouncer: a change is accepted only after it has been seen
    // continuously for DEBOUNCE_CYCLES cycles; a bounce back aborts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            accepted_q <= '0;
            for (int i = 0; i < N_FILL; i++) begin
                dbnc_state_q[i] <= ST_STABLE;
                dbnc_cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_FILL; i++) begin
                case (dbnc_state_q[i])
                    ST_STABLE: begin
                        if (sync2_q[i] != accepted_q[i]) begin
                            dbnc_state_q[i] <= ST_COUNT;
                            dbnc_cnt_q[i]   <= '0;
                        end else begin
                            dbnc_state_q[i] <= ST_STABLE;
                        end
                    end
                    ST_COUNT: begin
                        if (sync2_q[i] == accepted_q[i]) begin
                            dbnc_state_q[i] <= ST_STABLE;
                            dbnc_cnt_q[i]   <= '0;
                        end else if (dbnc_cnt_q[i] == CNT_LAST) begin
                            dbnc_state_q[i] <= ST_STABLE;
                            dbnc_cnt_q[i]   <= '0;
                            accepted_q[i]   <= sync2_q[i];
                        end else begin
                            dbnc_cnt_q[i]   <= dbnc_cnt_q[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        dbnc_state_q[i] <= ST_STABLE;
                        dbnc_cnt_q[i]   <= '0;
                    end
                endcase
            end
        end
    end

    assign dbnc_s = accepted_q;
`else
    assign dbnc_s = sync2_q;
`endif

    // Frame latch: buttons only change at frame_start so a frame never tears.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= '0;
        end else if (bus.frame_start) begin
            active_q <= dbnc_s;
        end else begin
            active_q <= active_q;
        end
    end

    // ---------------- pixel pipeline ----------------
    logic       in_region_s;
    logic [9:0] y_off_s;
    logic [7:0] row_d, row_q;
    logic [9:0] col_d, col_q;
    logic       vid1_q, reg1_q;
    logic       vid2_q, reg2_q;
    logic [11:0] rgb_d, rgb_q;
    logic        rgb_valid_q;
    logic        fill_hit_s;
    logic [11:0] fill_pix_s;

    // Stage 1 address generation; outside the image the ROMs see address 0.
    always_comb begin
        in_region_s = ({1'b0, bus.x} >= X_LO) && ({1'b0, bus.x} < X_HI) &&
                      ({1'b0, bus.y} >= Y_LO) && ({1'b0, bus.y} < Y_HI);
        y_off_s     = bus.y - 10'(ORIGIN_Y);
        if (in_region_s) begin
            row_d = y_off_s[7:0];
            col_d = bus.x - 10'(ORIGIN_X);
        end else begin
            row_d = 8'h00;
            col_d = 10'h000;
        end
    end

    // Stage 3 compositing: lowest-index pressed button with a non-transparent
    // fill pixel wins, otherwise the base image shows through.
    always_comb begin
        fill_hit_s = 1'b0;
        fill_pix_s = 12'h000;
        for (int i = 0; i < N_FILL; i++) begin
            if (!fill_hit_s && active_q[i] && (bus.fill_data[12*i +: 12] != 12'h000)) begin
                fill_hit_s = 1'b1;
                fill_pix_s = bus.fill_data[12*i +: 12];
            end else begin
                fill_hit_s = fill_hit_s;
            end
        end
        if (!vid2_q) begin
            rgb_d = 12'h000;
        end else if (!reg2_q) begin
            rgb_d = BG_COLOR;
        end else if (fill_hit_s) begin
            rgb_d = fill_pix_s;
        end else begin
            rgb_d = bus.base_data;
        end
    end

    // Pipeline registers; the stage-2 flags wait for the ROM read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_q       <= 8'h00;
            col_q       <= 10'h000;
            vid1_q      <= 1'b0;
            reg1_q      <= 1'b0;
            vid2_q      <= 1'b0;
            reg2_q      <= 1'b0;
            rgb_q       <= 12'h000;
            rgb_valid_q <= 1'b0;
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            vid1_q      <= bus.video_on;
            reg1_q      <= in_region_s;
            vid2_q      <= vid1_q;
            reg2_q      <= reg1_q;
            rgb_q       <= rgb_d;
            rgb_valid_q <= vid2_q;
        end
    end

    assign bus.row            = row_q;
    assign bus.col            = col_q;
    assign bus.rgb            = rgb_q;
    assign bus.rgb_valid      = rgb_valid_q;
    assign bus.active_buttons = active_q;
endmodule
